// File: rtl/moore_1101_pkg.sv
// rtl/moore_1101_pkg.sv - state encodings shared by the 1101 sequence detector
package moore_1101_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Each state names the longest useful prefix of 1-1-0-1 seen so far.
    localparam state_t S0 = 3'd0;  // no prefix
    localparam state_t S1 = 3'd1;  // "1"
    localparam state_t S2 = 3'd2;  // "11"
    localparam state_t S3 = 3'd3;  // "110"
    localparam state_t S4 = 3'd4;  // "1101" matched

endpackage

// File: rtl/moore_1101.sv
// rtl/moore_1101.sv - Moore detector for serial pattern 1-1-0-1
module moore_1101
    import moore_1101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entrada,
    output logic       salida,
    output logic [2:0] estado
);

    state_t state;
    state_t state_next;

    // State register; reset discards any partial match, including a held S4.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state table; unused encodings fall back to S0 so the machine self-recovers.
    always_comb begin
        state_next = S0;
        case (state)
            S0: state_next = entrada ? S1 : S0;
            S1: state_next = entrada ? S2 : S0;
            S2: state_next = entrada ? S2 : S3;
            S3: state_next = entrada ? S4 : S0;
            // After a match the trailing '1' either counts as "11" (overlap) or just "1".
            S4: state_next = entrada ? (OVERLAP ? S2 : S1) : S0;
            default: state_next = S0;
        endcase
    end

    // Output decode from the registered state only, so entrada never reaches salida.
    always_comb begin
        salida = (state == S4);
        estado = state;
    end

endmodule

// File: tb/tb_moore_1101.sv
// tb/tb_moore_1101.sv - scoreboard bench for the 1101 detector, both overlap modes
module tb_moore_1101;

    typedef struct {
        logic [2:0] st_ov;
        logic [2:0] st_no;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entrada = 1'b0;
    logic       salida_ov;
    logic [2:0] estado_ov;
    logic       salida_no;
    logic [2:0] estado_no;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    moore_1101 #(.OVERLAP(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .entrada (entrada),
        .salida  (salida_ov),
        .estado  (estado_ov)
    );

    moore_1101 #(.OVERLAP(1'b0)) dut_no (
        .clk     (clk),
        .reset   (reset),
        .entrada (entrada),
        .salida  (salida_no),
        .estado  (estado_no)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Drive one bit on the falling edge; record the states expected after the next rising edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s_ov,
                        input logic [2:0] s_no, input string name);
        exp_t x;
        @(negedge clk);
        reset   = r;
        entrada = e;
        x.st_ov = s_ov;
        x.st_no = s_no;
        x.name  = name;
        exp_q.push_back(x);
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check({x.name, " estado ov1"}, estado_ov, x.st_ov);
                check({x.name, " salida ov1"}, {2'b00, salida_ov}, {2'b00, x.st_ov == 3'd4});
                check({x.name, " estado ov0"}, estado_no, x.st_no);
                check({x.name, " salida ov0"}, {2'b00, salida_no}, {2'b00, x.st_no == 3'd4});
            end
        end
    end

    initial begin
        exp_t x;
        int   wait_cycles;

        // Reset, then idle zeros.
        step(1, 0, 3'd0, 3'd0, "reset");
        step(0, 0, 3'd0, 3'd0, "idle0");
        step(0, 0, 3'd0, 3'd0, "idle1");

        // Basic match 1,1,0,1 then a 0.
        step(0, 1, 3'd1, 3'd1, "basic b1");
        step(0, 1, 3'd2, 3'd2, "basic b2");
        step(0, 0, 3'd3, 3'd3, "basic b3");
        step(0, 1, 3'd4, 3'd4, "basic b4");
        step(0, 0, 3'd0, 3'd0, "basic tail");

        // Overlap 1,1,0,1,1,0,1 from a clean reset.
        step(1, 0, 3'd0, 3'd0, "ov reset");
        step(0, 1, 3'd1, 3'd1, "ov b1");
        step(0, 1, 3'd2, 3'd2, "ov b2");
        step(0, 0, 3'd3, 3'd3, "ov b3");
        step(0, 1, 3'd4, 3'd4, "ov b4");
        step(0, 1, 3'd2, 3'd1, "ov b5");
        step(0, 0, 3'd3, 3'd0, "ov b6");
        step(0, 1, 3'd4, 3'd1, "ov b7");

        // Reset mid-sequence with entrada=1, then 0,0,1,1,0,1.
        step(1, 0, 3'd0, 3'd0, "mid reset0");
        step(0, 1, 3'd1, 3'd1, "mid b1");
        step(0, 1, 3'd2, 3'd2, "mid b2");
        step(1, 1, 3'd0, 3'd0, "mid reset1");
        step(0, 0, 3'd0, 3'd0, "mid c1");
        step(0, 0, 3'd0, 3'd0, "mid c2");
        step(0, 1, 3'd1, 3'd1, "mid c3");
        step(0, 1, 3'd2, 3'd2, "mid c4");
        step(0, 0, 3'd3, 3'd3, "mid c5");
        step(0, 1, 3'd4, 3'd4, "mid c6");

        // Reset held while in S4.
        step(1, 1, 3'd0, 3'd0, "reset in s4");

        // Near-misses 1,1,1,0,0,1,0,1.
        step(0, 1, 3'd1, 3'd1, "near b1");
        step(0, 1, 3'd2, 3'd2, "near b2");
        step(0, 1, 3'd2, 3'd2, "near b3");
        step(0, 0, 3'd3, 3'd3, "near b4");
        step(0, 0, 3'd0, 3'd0, "near b5");
        step(0, 1, 3'd1, 3'd1, "near b6");
        step(0, 0, 3'd0, 3'd0, "near b7");
        step(0, 1, 3'd1, 3'd1, "near b8");

        // Illegal encoding 110: recover to S0 on the next edge even with entrada=1.
        @(negedge clk);
        force dut.state = 3'b110;
        force dut_no.state = 3'b110;
        #1;
        check("illegal estado ov1", estado_ov, 3'b110);
        check("illegal salida ov1", {2'b00, salida_ov}, 3'b000);
        check("illegal estado ov0", estado_no, 3'b110);
        check("illegal salida ov0", {2'b00, salida_no}, 3'b000);
        release dut.state;
        release dut_no.state;
        reset   = 1'b0;
        entrada = 1'b1;
        x.st_ov = 3'd0;
        x.st_no = 3'd0;
        x.name  = "illegal recover";
        exp_q.push_back(x);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
